pong_game_ctrl: RTL and testbench

Top-level game sequencer for the two-player VGA pong design. It consumes the hit/miss events produced by the pong graphics unit and the players' buttons, and runs the game state machine (new game, play, new ball, over). It owns the score counters, the rally counter and the inter-serve / game-over delay timer, and drives gra_still to freeze the ball/paddle datapath between rallies. The text/score overlay and top-level rgb mux read its registered outputs.

---
 rtl/pong_game_ctrl_if.sv | 30 +++
 rtl/pong_game_ctrl.sv | 132 +++++++++++++
 tb/tb_pong_game_ctrl.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_ctrl_if.sv
// Pong game controller bus: graphics/button events in, game status out.
// Combinational bundle only; timing is set by the controller that owns it.
// No backpressure: every event is a single-cycle pulse or a level.
interface pong_game_ctrl_if;
  logic [1:0] btn1;
  logic [1:0] btn2;
  logic       refr_tick;
  logic       hit;
  logic       miss_l;
  logic       miss_r;
  logic       gra_still;
  logic [1:0] state;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic [7:0] rally;
  logic       serve_dir;
  logic       winner;

  // Event source side (graphics unit, buttons) and overlay reader.
  modport master (
    output btn1, btn2, refr_tick, hit, miss_l, miss_r,
    input  gra_still, state, score_l, score_r, rally, serve_dir, winner
  );

  // Game controller side.
  modport slave (
    input  btn1, btn2, refr_tick, hit, miss_l, miss_r,
    output gra_still, state, score_l, score_r, rally, serve_dir, winner
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: scores, rally count, serve/game-over delay timer.
// One-cycle latency: every output is registered and moves on the edge after its cause.
// No backpressure: events arriving outside the state that uses them are dropped.
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int DELAY_FRAMES = 120,
  parameter int TIMER_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  pong_game_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  localparam logic [3:0]         WIN   = 4'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] DELAY = TIMER_W'(DELAY_FRAMES);

  state_t             state_q;
  logic               gra_still_q;
  logic [3:0]         score_l_q;
  logic [3:0]         score_r_q;
  logic [7:0]         rally_q;
  logic               serve_dir_q;
  logic               winner_q;
  logic [TIMER_W-1:0] timer_q;

  logic               any_btn;
  logic [3:0]         score_l_d;
  logic [3:0]         score_r_d;
  logic               timer_zero;

  assign any_btn    = (|bus.btn1) | (|bus.btn2);
  assign score_l_d  = score_l_q + 4'd1;
  assign score_r_d  = score_r_q + 4'd1;
  assign timer_zero = (timer_q == '0);

  // Game FSM with all outputs, counters and the delay timer registered together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= NEWGAME;
      gra_still_q <= 1'b1;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      rally_q     <= 8'd0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      case (state_q)
        NEWGAME: begin
          // Scores of the last game stay visible until someone starts a new one.
          if (any_btn) begin
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            rally_q     <= 8'd0;
            serve_dir_q <= 1'b0;
            state_q     <= PLAY;
            gra_still_q <= 1'b0;
          end
        end

        PLAY: begin
          // miss_l has priority over miss_r; any miss masks a coincident hit.
          if (bus.miss_l) begin
            score_r_q   <= score_r_d;
            serve_dir_q <= 1'b0;
            timer_q     <= DELAY;
            gra_still_q <= 1'b1;
            if (score_r_d == WIN) begin
              state_q  <= OVER;
              winner_q <= 1'b1;
            end else begin
              state_q  <= NEWBALL;
            end
          end else if (bus.miss_r) begin
            score_l_q   <= score_l_d;
            serve_dir_q <= 1'b1;
            timer_q     <= DELAY;
            gra_still_q <= 1'b1;
            if (score_l_d == WIN) begin
              state_q  <= OVER;
              winner_q <= 1'b0;
            end else begin
              state_q  <= NEWBALL;
            end
          end else if (bus.hit && (rally_q != 8'hFF)) begin
            rally_q <= rally_q + 8'd1;
          end
        end

        NEWBALL: begin
          // Button is a level: one held through the delay serves as soon as it expires.
          if (!timer_zero) begin
            if (bus.refr_tick) timer_q <= timer_q - 1'b1;
          end else if (any_btn) begin
            rally_q     <= 8'd0;
            state_q     <= PLAY;
            gra_still_q <= 1'b0;
          end
        end

        OVER: begin
          if (!timer_zero) begin
            if (bus.refr_tick) timer_q <= timer_q - 1'b1;
          end else begin
            state_q <= NEWGAME;
          end
        end

        default: begin
          state_q     <= NEWGAME;
          gra_still_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.gra_still = gra_still_q;
  assign bus.state     = state_q;
  assign bus.score_l   = score_l_q;
  assign bus.score_r   = score_r_q;
  assign bus.rally     = rally_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: vector table, directed corner sequences,
// then randomized events against a rule-level game model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that point.
module tb_pong_game_ctrl;

  localparam int WIN   = 9;
  localparam int DELAY = 120;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .WIN_SCORE    (WIN),
    .DELAY_FRAMES (DELAY),
    .TIMER_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Rule-level game model: phase 0 new game, 1 play, 2 new ball, 3 over.
  int m_phase, m_sl, m_sr, m_rally, m_sdir, m_win, m_timer;

  task automatic model_step(input bit r, input bit [1:0] b1, input bit [1:0] b2,
                            input bit t, input bit h, input bit ml, input bit mr);
    bit pressed;
    pressed = (b1 != 0) || (b2 != 0);
    if (r) begin
      m_phase = 0; m_sl = 0; m_sr = 0; m_rally = 0; m_sdir = 0; m_win = 0; m_timer = 0;
    end else if (m_phase == 0) begin
      if (pressed) begin
        m_sl = 0; m_sr = 0; m_rally = 0; m_sdir = 0; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (ml || mr) begin
        if (ml) begin
          m_sr = m_sr + 1; m_sdir = 0;
        end else begin
          m_sl = m_sl + 1; m_sdir = 1;
        end
        m_timer = DELAY;
        if ((ml ? m_sr : m_sl) == WIN) begin
          m_phase = 3; m_win = ml ? 1 : 0;
        end else begin
          m_phase = 2;
        end
      end else if (h) begin
        m_rally = (m_rally + 1 > 255) ? 255 : m_rally + 1;
      end
    end else begin
      if (m_timer > 0) begin
        if (t) m_timer = m_timer - 1;
      end else if (m_phase == 3) begin
        m_phase = 0;
      end else if (pressed) begin
        m_rally = 0; m_phase = 1;
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("state",     int'(bus.state),     m_phase);
    chk("gra_still", int'(bus.gra_still), (m_phase != 1) ? 1 : 0);
    chk("score_l",   int'(bus.score_l),   m_sl);
    chk("score_r",   int'(bus.score_r),   m_sr);
    chk("rally",     int'(bus.rally),     m_rally);
    chk("serve_dir", int'(bus.serve_dir), m_sdir);
    chk("winner",    int'(bus.winner),    m_win);
  endtask

  // One clock: drive inputs, advance the model with the same inputs, compare after the edge.
  task automatic cyc(input bit r, input bit [1:0] b1, input bit [1:0] b2,
                     input bit t, input bit h, input bit ml, input bit mr);
    reset         = r;
    bus.btn1      = b1;
    bus.btn2      = b2;
    bus.refr_tick = t;
    bus.hit       = h;
    bus.miss_l    = ml;
    bus.miss_r    = mr;
    @(posedge clk);
    model_step(r, b1, b2, t, h, ml, mr);
    #1;
    cmp_model();
  endtask

  task automatic idle();
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
  endtask

  // Run out the new-ball delay with ticks every cycle, then press to serve.
  task automatic serve();
    repeat (DELAY) cyc(0, 2'b00, 2'b00, 1, 0, 0, 0);
    cyc(0, 2'b01, 2'b00, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit       rst;
    bit [1:0] b1, b2;
    bit       t, h, ml, mr;
    int       st, sl, sr, ra, sd, still;
  } vec_t;

  function automatic vec_t mkv(bit rst, bit [1:0] b1, bit [1:0] b2, bit t, bit h, bit ml, bit mr,
                               int st, int sl, int sr, int ra, int sd, int still);
    vec_t v;
    v.rst = rst; v.b1 = b1; v.b2 = b2; v.t = t; v.h = h; v.ml = ml; v.mr = mr;
    v.st = st; v.sl = sl; v.sr = sr; v.ra = ra; v.sd = sd; v.still = still;
    return v;
  endfunction

  vec_t vt[11];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.btn1 = 2'b00; bus.btn2 = 2'b00; bus.refr_tick = 0;
    bus.hit = 0; bus.miss_l = 0; bus.miss_r = 0;

    //            rst b1     b2     t  h  ml mr   st sl sr ra sd still
    vt[0]  = mkv(1, 2'b00, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1);
    vt[1]  = mkv(0, 2'b00, 2'b00, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1);
    vt[2]  = mkv(0, 2'b00, 2'b01, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    vt[3]  = mkv(0, 2'b00, 2'b00, 0, 1, 0, 0,   1, 0, 0, 1, 0, 0);
    vt[4]  = mkv(0, 2'b11, 2'b00, 0, 1, 0, 0,   1, 0, 0, 2, 0, 0);
    vt[5]  = mkv(0, 2'b00, 2'b00, 0, 1, 0, 0,   1, 0, 0, 3, 0, 0);
    vt[6]  = mkv(0, 2'b00, 2'b00, 0, 1, 0, 1,   2, 1, 0, 3, 1, 1);
    vt[7]  = mkv(0, 2'b10, 2'b00, 0, 1, 1, 0,   2, 1, 0, 3, 1, 1);
    vt[8]  = mkv(1, 2'b00, 2'b00, 1, 1, 0, 0,   0, 0, 0, 0, 0, 1);
    vt[9]  = mkv(0, 2'b01, 2'b00, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    vt[10] = mkv(0, 2'b00, 2'b00, 0, 1, 1, 1,   2, 0, 1, 0, 0, 1);

    @(posedge clk); #1;

    // Reset, then 10 idle clocks with no buttons: the controller waits in NEWGAME.
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0);
    repeat (10) idle();
    chk("idle_state", int'(bus.state), 0);

    // Vector table.
    for (int i = 0; i < 11; i++) begin
      cyc(vt[i].rst, vt[i].b1, vt[i].b2, vt[i].t, vt[i].h, vt[i].ml, vt[i].mr);
      chk($sformatf("vec%0d_state", i), int'(bus.state),     vt[i].st);
      chk($sformatf("vec%0d_sl", i),    int'(bus.score_l),   vt[i].sl);
      chk($sformatf("vec%0d_sr", i),    int'(bus.score_r),   vt[i].sr);
      chk($sformatf("vec%0d_rally", i), int'(bus.rally),     vt[i].ra);
      chk($sformatf("vec%0d_sdir", i),  int'(bus.serve_dir), vt[i].sd);
      chk($sformatf("vec%0d_still", i), int'(bus.gra_still), vt[i].still);
    end

    // NEWBALL with btn1 held: no exit before the last tick, PLAY one clock after timer hits 0.
    for (int i = 1; i <= DELAY; i++) begin
      cyc(0, 2'b01, 2'b00, 1, 0, 0, 0);
      chk($sformatf("hold_tick%0d_state", i), int'(bus.state), 2);
    end
    cyc(0, 2'b01, 2'b00, 1, 0, 0, 0);
    chk("hold_exit_state", int'(bus.state), 1);
    chk("hold_exit_rally", int'(bus.rally), 0);

    // Fresh game: left player wins 9/0, OVER ignores buttons, NEWGAME keeps the result shown.
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b00, 2'b10, 0, 0, 0, 0);
    for (int p = 0; p < WIN - 1; p++) begin
      cyc(0, 2'b00, 2'b00, 0, 0, 0, 1);
      serve();
    end
    chk("pre_win_sl", int'(bus.score_l), 8);
    cyc(0, 2'b00, 2'b00, 0, 1, 0, 1);
    chk("win_state",  int'(bus.state),   3);
    chk("win_sl",     int'(bus.score_l), 9);
    chk("win_winner", int'(bus.winner),  0);
    for (int i = 1; i <= DELAY; i++) begin
      cyc(0, 2'b11, 2'b11, 1, 0, 0, 0);
      chk($sformatf("over_tick%0d_state", i), int'(bus.state), 3);
    end
    cyc(0, 2'b11, 2'b00, 0, 0, 0, 0);
    chk("over_exit_state", int'(bus.state),   0);
    chk("over_exit_sl",    int'(bus.score_l), 9);
    chk("over_exit_sr",    int'(bus.score_r), 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("newgame_hold_sl", int'(bus.score_l), 9);
    cyc(0, 2'b00, 2'b01, 0, 0, 0, 0);
    chk("restart_state", int'(bus.state),   1);
    chk("restart_sl",    int'(bus.score_l), 0);

    // 300 hits in a single rally saturate at 255.
    repeat (300) cyc(0, 2'b00, 2'b00, 0, 1, 0, 0);
    chk("rally_sat", int'(bus.rally), 255);

    // Right player wins 0/9 with a saturated first rally; winner flag must read 1.
    for (int p = 0; p < WIN - 1; p++) begin
      cyc(0, 2'b00, 2'b00, 0, 0, 1, 0);
      serve();
    end
    cyc(0, 2'b00, 2'b00, 0, 0, 1, 0);
    chk("rwin_state",  int'(bus.state),  3);
    chk("rwin_winner", int'(bus.winner), 1);

    // Reset in OVER returns everything to reset values on the next edge.
    repeat (30) cyc(0, 2'b00, 2'b00, 1, 0, 0, 0);
    cyc(1, 2'b01, 2'b00, 1, 0, 0, 0);
    chk("rst_over_state",  int'(bus.state),  0);
    chk("rst_over_winner", int'(bus.winner), 0);
    chk("rst_over_sr",     int'(bus.score_r), 0);

    // Reset in NEWBALL with timer at 57, coincident with a button and a tick.
    cyc(0, 2'b01, 2'b00, 0, 0, 0, 0);
    repeat (5) cyc(0, 2'b00, 2'b00, 0, 1, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 1);
    repeat (DELAY - 57) cyc(0, 2'b00, 2'b00, 1, 0, 0, 0);
    chk("mid_timer_model", m_timer, 57);
    chk("mid_state", int'(bus.state), 2);
    cyc(1, 2'b11, 2'b11, 1, 1, 1, 1);
    chk("rst_nb_state", int'(bus.state),     0);
    chk("rst_nb_still", int'(bus.gra_still), 1);
    chk("rst_nb_sl",    int'(bus.score_l),   0);
    chk("rst_nb_sdir",  int'(bus.serve_dir), 0);
    chk("rst_nb_rally", int'(bus.rally),     0);
    // The timer was cleared: after a new game and a point, the full delay is needed again.
    cyc(0, 2'b01, 2'b00, 0, 0, 0, 0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 1);
    repeat (DELAY - 1) cyc(0, 2'b01, 2'b00, 1, 0, 0, 0);
    chk("post_rst_delay_state", int'(bus.state), 2);

    // Randomized play against the model.
    for (int i = 0; i < 6000; i++) begin
      bit       r, t, h, ml, mr;
      bit [1:0] b1, b2;
      r  = ($urandom_range(0, 799) == 0);
      t  = ($urandom_range(0, 1) == 0);
      h  = ($urandom_range(0, 3) == 0);
      ml = ($urandom_range(0, 19) == 0);
      mr = ($urandom_range(0, 19) == 0);
      b1 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      b2 = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc(r, b1, b2, t, h, ml, mr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
